// File: rtl/count_uart_pkg.sv
// Shared types and constants for the counter-to-UART logger.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_uart_pkg;

    localparam int         DATA_BITS  = 8;
    localparam logic       IDLE_LEVEL = 1'b1;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Nibble to uppercase ASCII hex digit
    function automatic logic [7:0] hex_char(input logic [3:0] v);
        if (v < 4'd10) begin
            return ASCII_0 + {4'h0, v};
        end
        return ASCII_A + {4'h0, v} - 8'd10;
    endfunction

endpackage

// File: rtl/count_uart_fifo.sv
// Character queue between the count sampler and the UART framer.
// Latency: a pushed byte is visible at the head on the next cycle; never popped in its push cycle.
// Backpressure: none upstream; a push while full (without a pop) is dropped and flagged on drop.
module count_uart_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] pop_dat,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   occ_q;
    logic          wr_en;
    logic          rd_en;

    assign full    = (occ_q == DEPTH_C);
    assign empty   = (occ_q == '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign wr_en   = push && (!full || pop);
    // Empty-queue pops are ignored, so a same-cycle push waits for a later pop.
    assign rd_en   = pop && !empty;
    assign drop    = push && full && !pop;
    assign pop_dat = mem[rd_ptr_q];

    // Storage array; contents need no reset because occupancy guards reads
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/count_uart_tx.sv
// Samples the 4-bit counter and sends each change as an ASCII hex UART frame (8N1, or 8E1 with COUNT_UART_TX_PARITY_EN).
// Latency: count change captured at edge N, tx_o start bit begins at edge N+3 when the line is idle.
// Backpressure: none; changes arriving while the queue is full are dropped and overflow_o sticks high.
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [3:0] count_i,
    output logic       tx_o,
    output logic       tx_oeb_o,
    output logic       busy_o,
    output logic       overflow_o
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    logic [3:0]  cnt_q;
    logic [3:0]  last_q;
    logic        cnt_vld_q;
    logic        primed_q;
    logic        overflow_q;
    logic        sample_push;

    logic [7:0]  fifo_dat;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;
    logic        fifo_pop;

    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [15:0] baud_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  data_q;
    logic        baud_done;
    logic        tx_d;
    logic        busy_d;
    logic        tx_q;
    logic        busy_q;
    logic        oeb_q;

    // cnt_vld_q keeps the reset value of cnt_q from being sent as a real sample.
    assign sample_push = cnt_vld_q && (!primed_q || (cnt_q != last_q));
    assign baud_done   = (baud_q == 16'd0);

    // Sampler: register the counter and remember the last value queued
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q      <= 4'h0;
            last_q     <= 4'h0;
            cnt_vld_q  <= 1'b0;
            primed_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q     <= count_i;
            cnt_vld_q <= 1'b1;
            if (sample_push) begin
                last_q   <= cnt_q;
                primed_q <= 1'b1;
            end
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    count_uart_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .push     (sample_push),
        .push_dat (hex_char(cnt_q)),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; STOP hands straight to START so queued frames run back-to-back
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) state_d = DATA;
            end
            DATA: begin
                if (baud_done && (bit_idx_q == LAST_BIT)) begin
`ifdef COUNT_UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef COUNT_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level and busy status for the current state, registered below
    always_comb begin
        tx_d   = IDLE_LEVEL;
        busy_d = (state_q != IDLE) || !fifo_empty;
        case (state_q)
            START:  tx_d = 1'b0;
            DATA:   tx_d = data_q[bit_idx_q];
`ifdef COUNT_UART_TX_PARITY_EN
            PARITY: tx_d = ^data_q;
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    // Baud timer, bit index and frame byte; the timer reloads at every bit boundary
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
        end else begin
            if (fifo_pop) begin
                data_q <= fifo_dat;
            end
            if (fifo_pop || ((state_q != IDLE) && baud_done)) begin
                baud_q <= BAUD_RELOAD;
            end else if (state_q != IDLE) begin
                baud_q <= baud_q - 16'd1;
            end
            if ((state_q == DATA) && baud_done) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
        end
    end

    // Registered pad outputs; reset forces the line high without a clock
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx_q   <= IDLE_LEVEL;
            busy_q <= 1'b0;
            oeb_q  <= 1'b1;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            oeb_q  <= 1'b0;
        end
    end

    assign tx_o       = tx_q;
    assign tx_oeb_o   = oeb_q;
    assign busy_o     = busy_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: stimulus queues expected bytes, a line monitor decodes frames and checks them.
// Latency: checks start-bit latency of 3 cycles and frame/gap lengths.
// Backpressure: exercises queue overflow and mid-frame reset.
module tb_count_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef COUNT_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [3:0] count_i  = 4'h0;
    logic       tx_o;
    logic       tx_oeb_o;
    logic       busy_o;
    logic       overflow_o;

    int         cyc    = 0;
    int         checks = 0;
    int         fails  = 0;
    int         frames = 0;
    logic [7:0] exp_q[$];
    int         falls[$];

    count_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .count_i    (count_i),
        .tx_o       (tx_o),
        .tx_oeb_o   (tx_oeb_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int fall_at(input int back);
        if (falls.size() > back) return falls[falls.size() - 1 - back];
        return -1000000;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic wait_idle(input string nm, output int t);
        int n;
        n = 0;
        tick(5);
        while (busy_o !== 1'b0 && n < 3000) begin
            tick(1);
            n++;
        end
        check({nm, " idle timeout"}, 32'(busy_o), 0);
        t = cyc;
    endtask

    // Line monitor: decode each frame at bit centres and compare against the scoreboard
    initial begin : monitor
        logic [NBITS-1:0] bits;
        logic [7:0]       want;
        int               fall;
        bit               ab;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i === 1'b0 && tx_o === 1'b0) begin
                fall = cyc;
                ab   = 1'b0;
                bits = '0;
                for (int b = 0; b < NBITS && !ab; b++) begin
                    for (int k = 0; k < ((b == 0) ? DIV / 2 : DIV) && !ab; k++) begin
                        @(negedge wb_clk_i);
                        if (wb_rst_i) ab = 1'b1;
                    end
                    bits[b] = tx_o;
                end
                if (ab) begin
                    while (wb_rst_i) @(negedge wb_clk_i);
                end else begin
                    frames++;
                    falls.push_back(fall);
                    check("start bit", 32'(bits[0]), 0);
                    check("stop bit", 32'(bits[NBITS-1]), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected frame: got %02h, required no frame", bits[8:1]);
                    end else begin
                        want = exp_q.pop_front();
                        check("frame byte", 32'(bits[8:1]), 32'(want));
`ifdef COUNT_UART_TX_PARITY_EN
                        check("parity bit", 32'(bits[9]), 32'(^want));
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        int na;

        // Reset state, then the first value after reset is sent once
        count_i  = 4'h0;
        wb_rst_i = 1'b1;
        tick(3);
        check("reset tx_o", 32'(tx_o), 1);
        check("reset tx_oeb_o", 32'(tx_oeb_o), 1);
        check("reset busy_o", 32'(busy_o), 0);
        check("reset overflow_o", 32'(overflow_o), 0);
        exp_q.push_back(8'h30);
        wb_rst_i = 1'b0;
        tick(1);
        check("tx_oeb_o after release", 32'(tx_oeb_o), 0);
        wait_idle("frame0", t);
        check("frame0 length", 32'(t - fall_at(0)), 32'(FRAME));
        check("frame0 count", 32'(frames), 1);
        check("tx_o idle high", 32'(tx_o), 1);

        // 'A' then 'F', second queued during the first: back-to-back frames
        count_i = 4'hA;
        na = cyc + 1;
        exp_q.push_back(8'h41);
        tick(20);
        count_i = 4'hF;
        exp_q.push_back(8'h46);
        wait_idle("A/F", t);
        check("A start latency", 32'(fall_at(1) - na), 3);
        check("A to F spacing", 32'(fall_at(0) - fall_at(1)), 32'(FRAME));
        check("A/F frame count", 32'(frames), 3);

        // One change per cycle: one in flight plus four queued, the rest dropped
        for (int v = 0; v < 16; v++) begin
            count_i = 4'(v);
            if (v < 5) exp_q.push_back(8'h30 + 8'(v));
            tick(1);
        end
        tick(2);
        check("overflow set", 32'(overflow_o), 1);
        wait_idle("burst", t);
        check("overflow sticky", 32'(overflow_o), 1);
        check("burst frame count", 32'(frames), 8);

        // Reset during data bit 3 of '7' (bit 3 is 0), then resend '7'
        count_i = 4'h7;
        exp_q.push_back(8'h37);
        tick(20);
        check("tx_o in data bit 3", 32'(tx_o), 0);
        #1 wb_rst_i = 1'b1;
        #1;
        check("tx_o async high", 32'(tx_o), 1);
        check("overflow cleared", 32'(overflow_o), 0);
        check("busy cleared", 32'(busy_o), 0);
        tick(4);
        wb_rst_i = 1'b0;
        na = cyc + 1;
        wait_idle("resend", t);
        check("resend latency", 32'(fall_at(0) - na), 3);
        check("resend length", 32'(t - fall_at(0)), 32'(FRAME));
        check("final frame count", 32'(frames), 9);
        check("scoreboard drained", 32'(exp_q.size()), 0);
        check("overflow stays clear", 32'(overflow_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
